// File: rtl/alu_cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_cmd_seq_pkg
// Shared definitions for the ALU command sequencer: datapath sizes, command
// opcodes, ALU select codes and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_cmd_seq_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 4;
   localparam int REG_AW = $clog2(NREGS);

   // Command opcodes carried on cmd_op
   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   // ALU select codes driven on alu_op
   localparam logic ALU_PASS = 1'b0;
   localparam logic ALU_ADD  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      WB   = 2'b10
   } state_e;

endpackage : alu_cmd_seq_pkg

// File: rtl/alu_cmd_seq_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_seq_if
// Command handshake bundle between the control layer (master) and the
// sequencer (slave).
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer can accept a command
//   cmd_op     master->slave  opcode (MOV/ADD/LDI/NOP)
//   cmd_rd     master->slave  destination register
//   cmd_rs1    master->slave  source register 1
//   cmd_rs2    master->slave  source register 2 (ADD only)
//   cmd_imm    master->slave  immediate (LDI only)
// -----------------------------------------------------------------------------
interface alu_cmd_seq_if;
   import alu_cmd_seq_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [REG_AW-1:0] cmd_rd;
   logic [REG_AW-1:0] cmd_rs1;
   logic [REG_AW-1:0] cmd_rs2;
   logic [DATA_W-1:0] cmd_imm;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      output cmd_ready
   );

endinterface : alu_cmd_seq_if

// File: rtl/alu_cmd_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREGS x DATA_W register file for the command sequencer.
//   clk, rst          clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata  synchronous write port
//   raddr1 / rdata1   combinational read port (rs1)
//   raddr2 / rdata2   combinational read port (rs2)
//   dump_addr / dump_data  combinational observation port
// -----------------------------------------------------------------------------
module alu_regfile
   import alu_cmd_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [REG_AW-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // Next register contents: only the addressed entry changes on a write
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[waddr] = wdata;
      end else begin
         regs_d = regs_q;
      end
   end

   // Register storage with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata1    = regs_q[raddr1];
   assign rdata2    = regs_q[raddr2];
   assign dump_data = regs_q[dump_addr];

endmodule : alu_regfile

// File: rtl/alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// alu_cmd_seq
// Command sequencer driving an external 16-bit two-operation ALU
// (0 = pass in1, 1 = in1 + in2). Each accepted command takes three cycles:
// IDLE (accept, register ALU drive) -> EXEC (ALU settles, result captured)
// -> WB (done pulse, register write at end of cycle).
//   clk, rst     clock, synchronous active-high reset
//   cmd          command handshake (slave side of alu_cmd_seq_if)
//   alu_in1/2    registered ALU operands
//   alu_op       registered ALU select
//   alu_result   combinational ALU output
//   done         one-cycle completion pulse (WB cycle)
//   done_data    value written by the completing command (0 for NOP)
//   dump_sel     register select for observation
//   dump_data    combinational read of R[dump_sel]
// -----------------------------------------------------------------------------
module alu_cmd_seq
   import alu_cmd_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   alu_cmd_seq_if.slave      cmd,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic              alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic              done,
   output logic [DATA_W-1:0] done_data,
   input  logic [REG_AW-1:0] dump_sel,
   output logic [DATA_W-1:0] dump_data
);

   state_e            state_q,     state_d;
   logic [1:0]        op_q,        op_d;
   logic [REG_AW-1:0] rd_q,        rd_d;
   logic [DATA_W-1:0] alu_in1_q,   alu_in1_d;
   logic [DATA_W-1:0] alu_in2_q,   alu_in2_d;
   logic              alu_op_q,    alu_op_d;
   logic              done_q,      done_d;
   logic [DATA_W-1:0] done_data_q, done_data_d;

   logic              accept;
   logic              wb_we;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;

   // Ready is forced low during reset so nothing is accepted on a reset edge
   assign cmd.cmd_ready = (state_q == IDLE) & ~rst;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;

   // done_data_q doubles as the captured ALU result; NOP never writes back
   assign wb_we = (state_q == WB) & (op_q != OP_NOP);

   alu_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .we        (wb_we),
      .waddr     (rd_q),
      .wdata     (done_data_q),
      .raddr1    (cmd.cmd_rs1),
      .rdata1    (rs1_data),
      .raddr2    (cmd.cmd_rs2),
      .rdata2    (rs2_data),
      .dump_addr (dump_sel),
      .dump_data (dump_data)
   );

   // Sequencer next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_op_d    = alu_op_q;
      done_d      = 1'b0;
      done_data_d = done_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               op_d    = cmd.cmd_op;
               rd_d    = cmd.cmd_rd;
               case (cmd.cmd_op)
                  OP_MOV: begin
                     alu_op_d  = ALU_PASS;
                     alu_in1_d = rs1_data;
                     alu_in2_d = {DATA_W{1'b0}};
                  end
                  OP_ADD: begin
                     alu_op_d  = ALU_ADD;
                     alu_in1_d = rs1_data;
                     alu_in2_d = rs2_data;
                  end
                  OP_LDI: begin
                     // Immediate is routed through the ALU in pass mode
                     alu_op_d  = ALU_PASS;
                     alu_in1_d = cmd.cmd_imm;
                     alu_in2_d = {DATA_W{1'b0}};
                  end
                  default: begin
                     alu_op_d  = ALU_PASS;
                     alu_in1_d = {DATA_W{1'b0}};
                     alu_in2_d = {DATA_W{1'b0}};
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            // Capture at end of EXEC so done/done_data are registered in WB
            state_d     = WB;
            done_d      = 1'b1;
            done_data_d = (op_q == OP_NOP) ? {DATA_W{1'b0}} : alu_result;
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         rd_q        <= {REG_AW{1'b0}};
         alu_in1_q   <= {DATA_W{1'b0}};
         alu_in2_q   <= {DATA_W{1'b0}};
         alu_op_q    <= ALU_PASS;
         done_q      <= 1'b0;
         done_data_q <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_op_q    <= alu_op_d;
         done_q      <= done_d;
         done_data_q <= done_data_d;
      end
   end

   assign alu_in1   = alu_in1_q;
   assign alu_in2   = alu_in2_q;
   assign alu_op    = alu_op_q;
   assign done      = done_q;
   assign done_data = done_data_q;

endmodule : alu_cmd_seq

// File: tb/tb_alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_seq
// Directed and randomized bench for alu_cmd_seq. Includes a behavioural ALU
// and a register-array reference model of the command set. Inputs change and
// outputs are sampled at the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_seq;
   import alu_cmd_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic        alu_op;
   logic [15:0] alu_result;
   logic        done;
   logic [15:0] done_data;
   logic [1:0]  dump_sel;
   logic [15:0] dump_data;

   alu_cmd_seq_if cmd_if ();

   alu_cmd_seq dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cmd_if.slave),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .done       (done),
      .done_data  (done_data),
      .dump_sel   (dump_sel),
      .dump_data  (dump_data)
   );

   // External ALU: op 0 passes in1, op 1 adds (carry dropped by 16-bit result)
   assign alu_result = alu_op ? (alu_in1 + alu_in2) : alu_in1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] model [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input int idx, input logic [15:0] exp);
      dump_sel = idx[1:0];
      #1;
      chk($sformatf("R%0d", idx), {16'h0000, dump_data}, {16'h0000, exp});
   endtask

   task automatic chk_all_regs();
      for (int i = 0; i < 4; i++) chk_reg(i, model[i]);
   endtask

   // Issue one command starting at a falling edge in IDLE; returns at the
   // falling edge of T+3 with the model updated.
   task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [15:0] imm);
      logic [15:0] e_res, e_in1, e_in2;
      logic        e_aop;
      logic [16:0] sum;
      int          waited;
      sum = {1'b0, model[rs1]} + {1'b0, model[rs2]};
      case (op)
         2'd0:    begin e_res = model[rs1]; e_in1 = model[rs1]; e_in2 = 16'h0;       e_aop = 1'b0; end
         2'd1:    begin e_res = sum[15:0];  e_in1 = model[rs1]; e_in2 = model[rs2]; e_aop = 1'b1; end
         2'd2:    begin e_res = imm;        e_in1 = imm;        e_in2 = 16'h0;       e_aop = 1'b0; end
         default: begin e_res = 16'h0;      e_in1 = 16'h0;      e_in2 = 16'h0;       e_aop = 1'b0; end
      endcase
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_rd    = rd;
      cmd_if.cmd_rs1   = rs1;
      cmd_if.cmd_rs2   = rs2;
      cmd_if.cmd_imm   = imm;
      waited = 0;
      #1;
      while (cmd_if.cmd_ready !== 1'b1 && waited < 8) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("accept_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'($urandom);
      cmd_if.cmd_imm   = 16'($urandom);
      #1;
      chk("exec_in1", {16'h0, alu_in1}, {16'h0, e_in1});
      chk("exec_in2", {16'h0, alu_in2}, {16'h0, e_in2});
      chk("exec_aop", {31'd0, alu_op}, {31'd0, e_aop});
      chk("exec_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      chk("exec_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      #1;
      chk("wb_done", {31'd0, done}, 32'd1);
      chk("wb_data", {16'h0, done_data}, {16'h0, e_res});
      chk("wb_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      if (op != 2'd3) model[rd] = e_res;
      @(negedge clk);
      #1;
      chk("post_done", {31'd0, done}, 32'd0);
      chk("post_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      chk_reg(rd, model[rd]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] hold1, hold2;
      logic        holdop;
      rst = 1'b1;
      dump_sel = 2'd0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op  = 2'd3;
      cmd_if.cmd_rd  = 2'd0;
      cmd_if.cmd_rs1 = 2'd0;
      cmd_if.cmd_rs2 = 2'd0;
      cmd_if.cmd_imm = 16'h0;
      for (int i = 0; i < 4; i++) model[i] = 16'h0;

      // Reset: two cycles high, ready held low throughout
      @(negedge clk);
      #1 chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rel_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_aop", {31'd0, alu_op}, 32'd0);
      chk("rst_in1", {16'h0, alu_in1}, 32'd0);
      chk("rst_ddata", {16'h0, done_data}, 32'd0);
      chk_all_regs();

      // LDI R1, 0x1234
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 16'h1234);
      chk_reg(1, 16'h1234);

      // Carry wrap: 0xFFFF + 0x0002 = 0x0001
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 16'hFFFF);
      issue(OP_LDI, 2'd2, 2'd0, 2'd0, 16'h0002);
      issue(OP_ADD, 2'd3, 2'd1, 2'd2, 16'h0000);
      chk_reg(3, 16'h0001);

      // Back-to-back with valid held high; fields changed while busy
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op  = OP_LDI;
      cmd_if.cmd_rd  = 2'd0;
      cmd_if.cmd_imm = 16'h0005;
      @(negedge clk);
      cmd_if.cmd_op  = OP_ADD;
      cmd_if.cmd_rs1 = 2'd0;
      cmd_if.cmd_rs2 = 2'd0;
      cmd_if.cmd_imm = 16'hDEAD;
      #1;
      chk("b2b_t1_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      chk("b2b_t1_in1", {16'h0, alu_in1}, 32'h0005);
      @(negedge clk);
      #1 chk("b2b_t2_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      chk("b2b_t2_ddata", {16'h0, done_data}, 32'h0005);
      @(negedge clk);
      #1 chk("b2b_t3_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      #1;
      chk("b2b_add_aop", {31'd0, alu_op}, 32'd1);
      chk("b2b_add_in2", {16'h0, alu_in2}, 32'h0005);
      @(negedge clk);
      #1 chk("b2b_add_data", {16'h0, done_data}, 32'h000A);
      @(negedge clk);
      model[0] = 16'h000A;
      chk_reg(0, 16'h000A);

      // NOP with rd = 2 leaves R2 alone and reports zero
      issue(OP_LDI, 2'd2, 2'd0, 2'd0, 16'h00AA);
      issue(OP_NOP, 2'd2, 2'd1, 2'd1, 16'h5555);
      chk_reg(2, 16'h00AA);

      // Reset during EXEC of an ADD into R1: no done, all registers cleared
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op  = OP_ADD;
      cmd_if.cmd_rd  = 2'd1;
      cmd_if.cmd_rs1 = 2'd2;
      cmd_if.cmd_rs2 = 2'd2;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      rst = 1'b1;
      #1 chk("mid_rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) model[i] = 16'h0;
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_ready1", {31'd0, cmd_if.cmd_ready}, 32'd1);
      chk("mid_rst_in1", {16'h0, alu_in1}, 32'd0);
      chk_reg(1, 16'h0000);
      @(negedge clk);
      #1 chk("mid_rst_done2", {31'd0, done}, 32'd0);

      // Randomized commands with idle gaps against the reference model
      for (int n = 0; n < 60; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            hold1 = alu_in1;
            hold2 = alu_in2;
            holdop = alu_op;
            cmd_if.cmd_valid = 1'b0;
            cmd_if.cmd_op  = 2'($urandom);
            cmd_if.cmd_rs1 = 2'($urandom);
            cmd_if.cmd_imm = 16'($urandom);
            @(negedge clk);
            #1;
            chk("idle_in1", {16'h0, alu_in1}, {16'h0, hold1});
            chk("idle_in2", {16'h0, alu_in2}, {16'h0, hold2});
            chk("idle_aop", {31'd0, alu_op}, {31'd0, holdop});
            chk("idle_done", {31'd0, done}, 32'd0);
         end
         issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      end
      chk_all_regs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_alu_cmd_seq
